// File: rtl/guia_0702_arb_pkg.sv
// Shared definitions for the guia_0702 round-robin arbiter.
//   state_t   : arbiter sequencer states (IDLE, EVAL, RESP)
//   OP_OR/NOR : values of the per-requester select bit
//   STAT_MAX  : saturation value of the optional operation counters
package guia_0702_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_OR  = 1'b0;
  localparam logic OP_NOR = 1'b1;

  localparam logic [7:0] STAT_MAX = 8'hFF;

endpackage

// File: rtl/guia_0702_rr_pick.sv
// Combinational round-robin picker.
// Scans req cyclically starting at ptr and reports the first set bit.
//   req    : request vector (NREQ bits)
//   ptr    : index that has the highest priority this round
//   valid  : at least one request is set
//   winner : index of the granted requester (0 when valid is low)
module guia_0702_rr_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] winner
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr < NREQ, so a single conditional subtract implements mod NREQ
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NREQ)) begin
        sum = sum - (PTR_W+1)'(NREQ);
      end
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/guia_0702_arbiter.sv
// Round-robin arbiter/sequencer sharing one OR/NOR unit (Guia_0702) among
// NREQ requesters. The unit itself sits beside this block at the top level.
//
// Parameters:
//   NREQ        : number of requesters (2..8)
//   HOLD_CYCLES : cycles the operands are held on the unit before capture (>=1)
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   req/a/b/select        : per-requester request level and operands
//   gnt                   : one-hot grant, high from grant through done cycle
//   done                  : one-hot single-cycle completion pulse
//   result                : captured unit output (valid with done, held after)
//   busy                  : high while an operation is in EVAL or RESP
//   unit_a/b/select       : registered drive to the shared unit (0 in IDLE)
//   unit_result           : shared unit's selected_output
// Optional feature (macro GUIA0702_ARB_STATS_EN):
//   or_count, nor_count   : saturating counts of completed OR / NOR operations
module guia_0702_arbiter
  import guia_0702_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] a,
  input  logic [NREQ-1:0] b,
  input  logic [NREQ-1:0] select,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            result,
  output logic            busy,
  output logic            unit_a,
  output logic            unit_b,
  output logic            unit_select,
  input  logic            unit_result
`ifdef GUIA0702_ARB_STATS_EN
  ,
  output logic [7:0]      or_count,
  output logic [7:0]      nor_count
`endif
);

  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [CNT_W-1:0] cnt;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;

  guia_0702_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // The unit drive registers double as the latched operand registers; they
  // stay valid through RESP so the stats counters can read the latched select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      win         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      done        <= '0;
      result      <= 1'b0;
      busy        <= 1'b0;
      unit_a      <= 1'b0;
      unit_b      <= 1'b0;
      unit_select <= 1'b0;
`ifdef GUIA0702_ARB_STATS_EN
      or_count    <= '0;
      nor_count   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win         <= pick_idx;
            unit_a      <= a[pick_idx];
            unit_b      <= b[pick_idx];
            unit_select <= select[pick_idx];
            gnt         <= ONE_HOT0 << pick_idx;
            cnt         <= CNT_LOAD;
            busy        <= 1'b1;
            state       <= EVAL;
          end
        end

        EVAL: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            result <= unit_result;
            done   <= gnt;
            state  <= RESP;
          end
        end

        RESP: begin
          done        <= '0;
          gnt         <= '0;
          busy        <= 1'b0;
          unit_a      <= 1'b0;
          unit_b      <= 1'b0;
          unit_select <= 1'b0;
          ptr         <= (win == LAST_IDX) ? '0 : win + 1'b1;
          state       <= IDLE;
`ifdef GUIA0702_ARB_STATS_EN
          if (unit_select == OP_NOR) begin
            if (nor_count != STAT_MAX) nor_count <= nor_count + 8'd1;
          end else if (unit_select == OP_OR) begin
            if (or_count != STAT_MAX) or_count <= or_count + 8'd1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guia_0702_arbiter.sv
// Self-checking bench for guia_0702_arbiter: two instances (HOLD_CYCLES 1 and 3)
// share stimulus, each with its own OR/NOR unit model; a behavioural model
// tracks every instance cycle by cycle, and directed steps pin literal values.
module tb_guia_0702_arbiter;

  localparam int unsigned NREQ = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req = '0, a = '0, b = '0, sel = '0;

  logic [NREQ-1:0] g1, d1, g3, d3;
  logic r1, bz1, ua1, ub1, us1, ur1;
  logic r3, bz3, ua3, ub3, us3, ur3;
`ifdef GUIA0702_ARB_STATS_EN
  logic [7:0] oc1, nc1, oc3, nc3;
`endif

  // Guia_0702 unit models: select 0 = OR, 1 = NOR
  assign ur1 = us1 ? ~(ua1 | ub1) : (ua1 | ub1);
  assign ur3 = us3 ? ~(ua3 | ub3) : (ua3 | ub3);

  guia_0702_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .a(a), .b(b), .select(sel),
    .gnt(g1), .done(d1), .result(r1), .busy(bz1),
    .unit_a(ua1), .unit_b(ub1), .unit_select(us1), .unit_result(ur1)
`ifdef GUIA0702_ARB_STATS_EN
    , .or_count(oc1), .nor_count(nc1)
`endif
  );

  guia_0702_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req(req), .a(a), .b(b), .select(sel),
    .gnt(g3), .done(d3), .result(r3), .busy(bz3),
    .unit_a(ua3), .unit_b(ub3), .unit_select(us3), .unit_result(ur3)
`ifdef GUIA0702_ARB_STATS_EN
    , .or_count(oc3), .nor_count(nc3)
`endif
  );

  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: an operation is either absent or at age t (edges since grant).
  // Age HOLD is the done cycle, age HOLD+1 ends the operation.
  bit m_act[2];
  int m_t[2], m_w[2], m_ptr[2], m_oc[2], m_nc[2];
  bit m_la[2], m_lb[2], m_ls[2], m_res[2];

  function automatic int hold(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_step(input int i);
    if (reset) begin
      m_act[i] = 0; m_t[i] = 0; m_w[i] = 0; m_ptr[i] = 0;
      m_la[i] = 0; m_lb[i] = 0; m_ls[i] = 0; m_res[i] = 0;
      m_oc[i] = 0; m_nc[i] = 0;
    end else if (!m_act[i]) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_ptr[i] + k) % NREQ;
        if (!m_act[i] && req[idx]) begin
          m_act[i] = 1; m_w[i] = idx; m_t[i] = 0;
          m_la[i] = a[idx]; m_lb[i] = b[idx]; m_ls[i] = sel[idx];
        end
      end
    end else begin
      m_t[i]++;
      if (m_t[i] == hold(i)) begin
        m_res[i] = m_ls[i] ? !(m_la[i] | m_lb[i]) : (m_la[i] | m_lb[i]);
      end else if (m_t[i] == hold(i) + 1) begin
        m_act[i] = 0;
        m_ptr[i] = (m_w[i] + 1) % NREQ;
        if (m_ls[i]) m_nc[i] = (m_nc[i] < 255) ? m_nc[i] + 1 : 255;
        else         m_oc[i] = (m_oc[i] < 255) ? m_oc[i] + 1 : 255;
      end
    end
  endtask

  task automatic model_compare(input int i);
    logic [NREQ-1:0] one, eg, ed;
    string p;
    one = 1;
    eg  = m_act[i] ? (one << m_w[i]) : '0;
    ed  = (m_act[i] && m_t[i] == hold(i)) ? eg : '0;
    p   = $sformatf("h%0d", hold(i));
    check({p, " gnt"},    (i == 0) ? g1  : g3,  eg);
    check({p, " done"},   (i == 0) ? d1  : d3,  ed);
    check({p, " busy"},   (i == 0) ? bz1 : bz3, m_act[i]);
    check({p, " result"}, (i == 0) ? r1  : r3,  m_res[i]);
    check({p, " unit_a"}, (i == 0) ? ua1 : ua3, m_act[i] & m_la[i]);
    check({p, " unit_b"}, (i == 0) ? ub1 : ub3, m_act[i] & m_lb[i]);
    check({p, " unit_s"}, (i == 0) ? us1 : us3, m_act[i] & m_ls[i]);
`ifdef GUIA0702_ARB_STATS_EN
    check({p, " or_count"},  (i == 0) ? oc1 : oc3, m_oc[i]);
    check({p, " nor_count"}, (i == 0) ? nc1 : nc3, m_nc[i]);
`endif
  endtask

  always begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) model_compare(i);
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_d1_done(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (d1 == '0 && n < 20);
    if (d1 == '0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no done within 20 cycles, expected a done pulse", name);
    end
  endtask

  task automatic do_op(input string name, input logic [NREQ-1:0] rb, ab, bb, sb,
                       input logic exp_res);
    @(negedge clk);
    req = rb; a = ab; b = bb; sel = sb;
    tick();
    check({name, " gnt"}, g1, rb);
    @(negedge clk);
    req = '0;
    wait_d1_done(name);
    check({name, " done"}, d1, rb);
    check({name, " result"}, r1, exp_res);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset gnt", g1, 0);
    check("reset done", d1, 0);
    check("reset busy", bz1, 0);
    check("reset result", r3, 0);
    @(negedge clk) reset = 1'b0;

    // single OR request, HOLD_CYCLES = 1
    @(negedge clk);
    req = 4'b0001; a = 4'b0001; b = '0; sel = '0;
    tick();
    check("single gnt", g1, 4'b0001);
    check("single unit_a", ua1, 1);
    @(negedge clk) req = '0;
    tick();
    check("single done", d1, 4'b0001);
    check("single result", r1, 1);
    tick();
    check("single busy clear", bz1, 0);
    check("single gnt clear", g1, 0);
    repeat (8) @(negedge clk);

    // NOR path
    do_op("nor00", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1);
    do_op("nor11", 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b0);

    // contention: req0 and req1 held, pointer sits at 2 -> 0,1,0,1
    @(negedge clk);
    req = 4'b0011; a = '0; b = '0; sel = '0;
    for (int n = 0; n < 4; n++) begin
      wait_d1_done("rr");
      check($sformatf("rr winner %0d", n), d1, (n % 2 == 0) ? 4'b0001 : 4'b0010);
      if (n == 3) begin
        @(negedge clk) req = '0;
        tick();
        check("rr last done clear", d1, 0);
      end else begin
        tick();
        check("rr done single", d1, 0);
        check("rr idle gap", bz1, 0);
        tick();
        check("rr regrant", bz1, 1);
      end
    end
    repeat (8) @(negedge clk);

    // operands latched at grant; req drop does not cancel
    @(negedge clk);
    req = 4'b0001; a = 4'b0001; b = '0; sel = '0;
    tick();
    check("latch gnt", g1, 4'b0001);
    @(negedge clk);
    req = '0; a = '0; sel = 4'b0001;
    tick();
    check("latch done", d1, 4'b0001);
    check("latch result", r1, 1);
    repeat (8) @(negedge clk);

    // asynchronous reset in the middle of a HOLD_CYCLES = 3 evaluation
    @(negedge clk);
    req = 4'b0100; a = 4'b0100; b = '0; sel = '0;
    tick();
    check("midrst gnt", g3, 4'b0100);
    #2;
    req = '0;
    reset = 1'b1;
    #1;
    check("midrst gnt", g3, 0);
    check("midrst busy", bz3, 0);
    check("midrst unit_a", ua3, 0);
    check("midrst done", d3, 0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) req = 4'b0011;
    tick();
    check("postrst gnt h3", g3, 4'b0001);
    check("postrst gnt h1", g1, 4'b0001);
    @(negedge clk) req = '0;
    repeat (8) @(negedge clk);

`ifdef GUIA0702_ARB_STATS_EN
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    for (int n = 0; n < 3; n++) do_op("st_or", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    for (int n = 0; n < 2; n++) do_op("st_nor", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    check("stats or", oc1, 3);
    check("stats nor", nc1, 2);
    @(negedge clk);
    req = 4'b0001; a = '0; b = '0; sel = '0;
    for (int n = 0; n < 300; n++) wait_d1_done("st_sat");
    @(negedge clk) req = '0;
    repeat (8) @(negedge clk);
    check("stats or sat", oc1, 255);
    check("stats nor kept", nc1, 2);
`endif

    // randomized traffic, occasional resets
    repeat (3000) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      req   = NREQ'($urandom) & NREQ'($urandom);
      a     = NREQ'($urandom);
      b     = NREQ'($urandom);
      sel   = NREQ'($urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
